// File: rtl/eth_pkg.sv
// Shared Ethernet/IP receive-path definitions: UDP receiver state encodings,
// UDP header length and the IP protocol number that identifies UDP.
package eth_pkg;

    localparam logic [7:0] ST_IDLE = 8'd0;
    localparam logic [7:0] ST_WAIT = 8'd1;
    localparam logic [7:0] ST_WORK = 8'd2;
    localparam logic [7:0] ST_DONE = 8'd3;
    localparam logic [7:0] ST_HEAD = 8'd4;

    localparam logic [15:0] UDP_HLEN  = 16'd8;
    localparam logic [7:0]  UDP_PROTO = 8'h11;

endpackage

// File: rtl/udp_rx.sv
// UDP receive stage: strips the 8-byte UDP header from an IP payload and streams
// the datagram payload. Define UDP_PORT_FILTER_EN to accept only LOCAL_PORT.
module udp_rx
    import eth_pkg::*;
#(
    parameter logic [15:0] LOCAL_PORT = 16'h1F90,
    parameter logic [7:0]  UDP_PROTO  = eth_pkg::UDP_PROTO
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rxd,
    input  logic        fs,
    output logic        fd,
    input  logic [7:0]  ip_mode,
    output logic [15:0] src_port,
    output logic [15:0] det_port,
    output logic [15:0] udp_len,
    output logic [7:0]  data,
    output logic        data_vld,
    output logic        data_last,
    output logic        err,
    output logic [7:0]  dbg_state
);

    // Handshake: fs high marks a frame; the first cycle it is sampled high in WAIT
    // carries no data, header byte 0 follows on the next cycle, one byte per cycle.
    // data_vld is a single-cycle qualifier for data (no backpressure).

`ifdef UDP_PORT_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    logic [7:0]  r_state;
    logic [15:0] r_cnt;
    logic [15:0] r_plen;
    logic [15:0] r_src_port;
    logic [15:0] r_det_port;
    logic [15:0] r_udp_len;
    logic [7:0]  r_data;
    logic        r_accept;
    logic        r_fs_q;
    logic        r_data_vld;
    logic        r_data_last;
    logic        r_err;

    logic        w_port_ok;
    logic        w_fs_rise;
    logic        w_last_byte;
    logic        w_len_bad;

    assign w_port_ok   = !FILTER_EN || (r_det_port == LOCAL_PORT);
    assign w_fs_rise   = fs && !r_fs_q;
    assign w_last_byte = (r_cnt == r_plen - 16'd1);
    assign w_len_bad   = (r_udp_len < UDP_HLEN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_plen      <= '0;
            r_src_port  <= '0;
            r_det_port  <= '0;
            r_udp_len   <= '0;
            r_data      <= '0;
            r_accept    <= 1'b0;
            // Starting high means an fs already asserted at release is not a frame start.
            r_fs_q      <= 1'b1;
            r_data_vld  <= 1'b0;
            r_data_last <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_fs_q      <= fs;
            r_data_vld  <= 1'b0;
            r_data_last <= 1'b0;
            r_err       <= 1'b0;
            case (r_state)
                ST_IDLE: r_state <= ST_WAIT;
                ST_WAIT: begin
                    if (w_fs_rise) begin
                        r_state <= ST_HEAD;
                        r_cnt   <= '0;
                    end
                end
                ST_HEAD: begin
                    if (!fs) begin
                        r_state <= ST_WAIT;
                        r_err   <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        case (r_cnt[2:0])
                            3'd0: r_src_port[15:8] <= rxd;
                            3'd1: r_src_port[7:0]  <= rxd;
                            3'd2: r_det_port[15:8] <= rxd;
                            3'd3: r_det_port[7:0]  <= rxd;
                            3'd4: r_udp_len[15:8]  <= rxd;
                            3'd5: r_udp_len[7:0]   <= rxd;
                            3'd6: r_plen <= w_len_bad ? 16'd0 : (r_udp_len - UDP_HLEN);
                            3'd7: begin
                                r_err    <= w_len_bad;
                                r_accept <= (ip_mode == UDP_PROTO) && w_port_ok;
                                r_state  <= (r_plen != 16'd0) ? ST_WORK : ST_DONE;
                            end
                        endcase
                        r_cnt <= (r_cnt[2:0] == 3'd7) ? 16'd0 : (r_cnt + 16'd1);
                    end
                end
                ST_WORK: begin
                    if (!fs) begin
                        r_state <= ST_WAIT;
                        r_err   <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        // Rejected datagrams are still counted so DONE lines up with the frame.
                        if (r_accept) begin
                            r_data      <= rxd;
                            r_data_vld  <= 1'b1;
                            r_data_last <= w_last_byte;
                        end
                        if (w_last_byte) begin
                            r_state <= ST_DONE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                end
                ST_DONE: begin
                    if (!fs) r_state <= ST_WAIT;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign fd        = (r_state == ST_DONE);
    assign src_port  = r_src_port;
    assign det_port  = r_det_port;
    assign udp_len   = r_udp_len;
    assign data      = r_data;
    assign data_vld  = r_data_vld;
    assign data_last = r_data_last;
    assign err       = r_err;
    assign dbg_state = r_state;

endmodule

// File: doc/udp_rx.md
UDP_RX -- requirements
Module: udp_rx

Interface
REQ-001 The block SHALL have parameter LOCAL_PORT, default 16'h1F90, meaning the accepted UDP destination port.
REQ-002 The block SHALL have parameter UDP_PROTO, default 8'h11, meaning the IP protocol value that identifies UDP.
REQ-003 clk  input  1  sole clock; every register SHALL be rising-edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 rxd  input  8  IP payload byte from the upstream IP receive stage.
REQ-006 fs  input  1  frame start from the upstream stage; stays high for the whole payload.
REQ-007 fd  output  1  frame done to the upstream stage.
REQ-008 ip_mode  input  8  IP protocol field, stable while fs is high.
REQ-009 src_port  output  16  captured UDP source port.
REQ-010 det_port  output  16  captured UDP destination port.
REQ-011 udp_len  output  16  captured UDP length field.
REQ-012 data  output  8  accepted payload byte.
REQ-013 data_vld  output  1  data is valid this cycle.
REQ-014 data_last  output  1  final accepted payload byte, coincident with data_vld.
REQ-015 err  output  1  one-cycle pulse on a bad length or an aborted frame.

Function
REQ-016 States SHALL be IDLE, WAIT, HEAD, WORK, DONE; IDLE SHALL go to WAIT unconditionally.
REQ-017 WAIT SHALL go to HEAD when fs is sampled high, with cnt cleared.
REQ-018 In HEAD, rxd SHALL carry UDP header byte cnt (0..7), one byte per cycle, starting the first HEAD cycle.
REQ-019 Header capture: bytes 0-1 SHALL go to src_port[15:8]/[7:0], bytes 2-3 to det_port, bytes 4-5 to udp_len; bytes 6-7 (checksum) SHALL be ignored.
REQ-020 plen SHALL be udp_len - 8, 16-bit, computed at cnt==6.
REQ-021 If udp_len < 8, plen SHALL be forced to 0 and err SHALL pulse at cnt==7.
REQ-022 At cnt==7, accept SHALL be set to (ip_mode==UDP_PROTO) && port_ok.
REQ-023 After cnt==7, HEAD SHALL go to WORK if plen != 0, else to DONE; cnt SHALL be cleared.
REQ-024 In WORK, one byte SHALL be consumed per cycle for plen cycles, then the state SHALL go to DONE.
REQ-025 When accept=1, data SHALL equal rxd registered, and data_vld SHALL be high the cycle after each WORK cycle (latency 1).
REQ-026 When accept=0, data_vld SHALL stay 0 and bytes SHALL be discarded while still counted.
REQ-027 data_last SHALL be high with the data_vld of payload byte plen-1.
REQ-028 fd SHALL be high exactly while in DONE; DONE SHALL return to WAIT when fs is low.
REQ-029 If fs falls while in HEAD or WORK, the state SHALL go to WAIT, err SHALL pulse, fd SHALL not assert, and data_last SHALL not be issued.
REQ-030 Bytes arriving after plen while fs is still high (Ethernet padding) SHALL be ignored in DONE.
REQ-031 cnt SHALL be 16-bit and SHALL never wrap within a frame (plen ≤ 65527).

Reset
REQ-032 While rst_n=0, state SHALL be IDLE, and all outputs and cnt/plen/accept SHALL be 0.
REQ-033 Reset mid-frame SHALL discard the frame; after release the block SHALL wait for a fresh rising fs.

Configuration
REQ-034 With UDP_PORT_FILTER_EN defined, port_ok SHALL be (det_port==LOCAL_PORT).
REQ-035 Without UDP_PORT_FILTER_EN, port_ok SHALL be 1 and all ports SHALL be accepted.

Structure
REQ-036 Shared package eth_pkg SHALL hold the state encodings (8-bit: IDLE=0, WAIT=1, WORK=2, DONE=3, HEAD=4), UDP_HLEN=8, and UDP_PROTO.
REQ-037 The block SHALL be a single module with no sub-module.

Verification
REQ-038 Scenario: ip_mode=0x11, header 04D2 1F90 000C 0000, payload A1 B2 C3 D4 -> src_port=0x04D2, det_port=0x1F90, udp_len=12, four data_vld, data_last on D4, then fd until fs drops.
REQ-039 Scenario: ip_mode=0x06, same frame -> no data_vld, fd asserted after 4 payload cycles.
REQ-040 Scenario: UDP_PORT_FILTER_EN defined, det_port=0x0035 -> no data_vld, fd asserted; without the macro -> 4 bytes delivered.
REQ-041 Scenario: udp_len=0x0008, followed by 18 padding bytes -> no data_vld, DONE entered after the header, padding ignored.
REQ-042 Scenario: udp_len=0x0004 -> err pulse at header byte 7, plen=0, fd asserted.
REQ-043 Scenario: fs dropped after payload byte 2 of 4 -> err pulse, no data_last, no fd; the next frame is received correctly.
